// File: rtl/ascii_num_parser.sv
// ascii_num_parser: turns space-separated signed decimal tokens from the validator buffer into a valid/ready integer stream.
// Define ASCII_NUM_PARSER_SAT_EN to clamp overflowing tokens instead of aborting with err_code 3.
module ascii_num_parser #(
  parameter int MAX_PAYLOAD = 1200,
  parameter int NUM_WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 start,
  input  logic [7:0]           char_buf [MAX_PAYLOAD],
  input  logic [15:0]          buf_len,
  input  logic                 buf_invalid,
  output logic [NUM_WIDTH-1:0] num_data,
  output logic                 num_valid,
  input  logic                 num_ready,
  output logic [CNT_WIDTH-1:0] num_count,
  output logic                 done,
  output logic                 error,
  output logic [1:0]           err_code
);
  localparam int AW = $clog2(MAX_PAYLOAD);
  localparam int MW = NUM_WIDTH + 1;
  localparam int PW = NUM_WIDTH + 5;
  typedef enum logic [2:0] {IDLE, SCAN, EMIT, DONE, ERROR} state_t;
  state_t state, state_n;
  logic [15:0] rd_ptr;
  logic [MW-1:0] mag, mag_n;
  logic neg, in_tok, has_dig;
  logic [1:0] err_n;
  logic [7:0] ch;
  logic at_end, is_dig, is_minus, is_space, tok_end, ovf, ovf_err;
  logic [PW-1:0] prod, limit;
  assign ch = char_buf[rd_ptr[AW-1:0]];
  assign at_end = rd_ptr >= buf_len;
  assign is_dig = ch >= 8'h30 && ch <= 8'h39;
  assign is_minus = ch == 8'h2d;
  assign is_space = ch == 8'h20;
  assign tok_end = has_dig && (at_end || is_space);
  // Negative tokens may reach one more than positive ones.
  assign limit = (PW'(1) << (NUM_WIDTH - 1)) - PW'(!neg);
  assign prod = PW'(mag) * PW'(10) + PW'(ch[3:0]);
  assign ovf = prod > limit;
  assign mag_n = ovf ? MW'(limit) : MW'(prod);
`ifdef ASCII_NUM_PARSER_SAT_EN
  assign ovf_err = 1'b0;
`else
  assign ovf_err = ovf;
`endif
  assign num_valid = state == EMIT;
  assign done = state == DONE;
  assign error = state == ERROR;
  always_comb begin
    state_n = state;
    err_n = 2'd0;
    case (state)
      IDLE: begin
        err_n = start && buf_invalid ? 2'd1 : 2'd0;
        state_n = !start ? IDLE : buf_invalid ? ERROR : SCAN;
      end
      SCAN: begin
        err_n = (at_end || is_space) ? (in_tok && !has_dig ? 2'd2 : 2'd0)
              : is_dig ? (ovf_err ? 2'd3 : 2'd0)
              : is_minus ? (in_tok ? 2'd2 : 2'd0) : 2'd2;
        state_n = err_n != 2'd0 ? ERROR : tok_end ? EMIT : at_end ? DONE : SCAN;
      end
      EMIT: state_n = num_ready ? SCAN : EMIT;
      default: state_n = state;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rd_ptr <= '0;
      mag <= '0;
      neg <= 1'b0;
      in_tok <= 1'b0;
      has_dig <= 1'b0;
      num_data <= '0;
      num_count <= '0;
      err_code <= 2'd0;
    end else if (clear) begin
      state <= IDLE;
      rd_ptr <= '0;
      mag <= '0;
      neg <= 1'b0;
      in_tok <= 1'b0;
      has_dig <= 1'b0;
      num_data <= '0;
      num_count <= '0;
      err_code <= 2'd0;
    end else begin
      state <= state_n;
      if (err_n != 2'd0) err_code <= err_n;
      if (state == IDLE && start) begin
        rd_ptr <= '0;
        num_count <= '0;
      end
      if (state == SCAN && !at_end && state_n != ERROR) rd_ptr <= rd_ptr + 16'd1;
      if (state == SCAN && state_n == EMIT) num_data <= neg ? NUM_WIDTH'(-mag) : NUM_WIDTH'(mag);
      if (state == EMIT && num_ready) num_count <= &num_count ? num_count : num_count + CNT_WIDTH'(1);
      if (state == IDLE || state_n == EMIT) begin
        mag <= '0;
        neg <= 1'b0;
        in_tok <= 1'b0;
        has_dig <= 1'b0;
      end else if (state == SCAN && !at_end && is_dig) begin
        mag <= mag_n;
        in_tok <= 1'b1;
        has_dig <= 1'b1;
      end else if (state == SCAN && !at_end && is_minus) begin
        neg <= 1'b1;
        in_tok <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ascii_num_parser.sv
// tb_ascii_num_parser: table vectors, corner sequences and random buffers checked against a string-level model.
module tb_ascii_num_parser;
  localparam int MP = 64;
  localparam int CW = 3;
  logic clk = 1'b0;
  logic rst_n, clear, start, buf_invalid, num_ready;
  logic [7:0] cbuf [MP];
  logic [15:0] buf_len;
  logic [31:0] num_data;
  logic num_valid, done, error;
  logic [CW-1:0] num_count;
  logic [1:0] err_code;
  int tests = 0;
  int fails = 0;
  int got[$];
  int exp_q[$];
  int exp_code;
  int stable_bad;
  bit timed_out;
  typedef struct {
    string s;
    bit inval;
    int rmode;
    int n;
    int v0, v1, v2;
    int code;
  } vec_t;
  vec_t vt[15];

  ascii_num_parser #(.MAX_PAYLOAD(MP), .NUM_WIDTH(32), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .start(start), .char_buf(cbuf),
    .buf_len(buf_len), .buf_invalid(buf_invalid), .num_data(num_data), .num_valid(num_valid),
    .num_ready(num_ready), .num_count(num_count), .done(done), .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " num_valid"}, num_valid, 0);
    check({tag, " num_data"}, num_data, 0);
    check({tag, " num_count"}, num_count, 0);
    check({tag, " done"}, done, 0);
    check({tag, " error"}, error, 0);
    check({tag, " err_code"}, err_code, 0);
  endtask

  task automatic load(input string s);
    for (int i = 0; i < MP; i++) cbuf[i] = i < s.len() ? s[i] : 8'h20;
    buf_len = 16'(s.len());
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic run(input string s, input bit inval, input int rmode);
    int cyc;
    bit stalled;
    logic [31:0] held;
    pulse_clear();
    load(s);
    buf_invalid = inval;
    got.delete();
    stable_bad = 0;
    stalled = 1'b0;
    held = '0;
    @(negedge clk);
    start = 1'b1;
    for (cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (done || error) break;
      if (stalled && num_valid && num_data !== held) stable_bad++;
      num_ready = rmode == 0 ? 1'b1 : rmode == 1 ? (cyc % 3 == 0) : ($urandom_range(0, 3) == 0);
      if (num_valid && num_ready) got.push_back(int'(num_data));
      stalled = num_valid && !num_ready;
      held = num_data;
    end
    timed_out = cyc >= 2000;
    num_ready = 1'b0;
    buf_invalid = 1'b0;
  endtask

  task automatic compare(input string tag);
    check({tag, " timeout"}, timed_out, 0);
    check({tag, " count"}, got.size(), exp_q.size());
    for (int j = 0; j < exp_q.size() && j < got.size(); j++)
      check($sformatf("%s val%0d", tag, j), got[j], exp_q[j]);
    check({tag, " done"}, done, exp_code == 0);
    check({tag, " error"}, error, exp_code != 0);
    check({tag, " err_code"}, err_code, exp_code);
    check({tag, " num_count"}, num_count, exp_q.size() > 7 ? 7 : exp_q.size());
    check({tag, " stable"}, stable_bad, 0);
  endtask

  // Reference: walk whitespace-separated tokens, first fault in reading order decides the code.
  task automatic model(input string s, input bit inval);
    int pos;
    bit neg, dig;
    longint mag, lim;
    byte c;
    exp_q.delete();
    exp_code = inval ? 1 : 0;
    pos = 0;
    while (!inval && pos < s.len() && exp_code == 0) begin
      if (s[pos] == " ") pos++;
      else begin
        neg = 0;
        dig = 0;
        mag = 0;
        while (pos < s.len() && s[pos] != " " && exp_code == 0) begin
          c = s[pos];
          if (c == "-" && !neg && !dig) neg = 1;
          else if (c >= "0" && c <= "9") begin
            dig = 1;
            mag = mag * 10 + longint'(c - 8'd48);
            lim = neg ? (longint'(1) << 31) : (longint'(1) << 31) - 1;
`ifdef ASCII_NUM_PARSER_SAT_EN
            if (mag > lim) mag = lim;
`else
            if (mag > lim) exp_code = 3;
`endif
          end else exp_code = 2;
          pos++;
        end
        if (exp_code == 0) begin
          if (!dig) exp_code = 2;
          else exp_q.push_back(int'(neg ? -mag : mag));
        end
      end
    end
  endtask

  function automatic string gen();
    string s;
    longint m;
    int k;
    bit first;
    s = "";
    first = 1;
    repeat ($urandom_range(0, 2)) s = {s, " "};
    while (s.len() < 40) begin
      if (!first) repeat ($urandom_range(1, 3)) s = {s, " "};
      first = 0;
      k = $urandom_range(0, 19);
      if (k == 19) begin
        case ($urandom_range(0, 3))
          0: s = {s, "-"};
          1: s = {s, "3-3"};
          2: s = {s, "1a"};
          default: s = {s, "--2"};
        endcase
      end else begin
        m = k < 10 ? longint'($urandom_range(0, 9999)) : k < 13 ? 64'd2147483647 - longint'($urandom_range(0, 2))
          : k < 15 ? 64'd2147483648 + longint'($urandom_range(0, 2)) : longint'($urandom);
        if ($urandom_range(0, 1) == 1) s = {s, "-"};
        if (k == 5) s = {s, "0"};
        s = {s, $sformatf("%0d", m)};
      end
      if ($urandom_range(0, 5) == 0) break;
    end
    repeat ($urandom_range(0, 2)) s = {s, " "};
    return s;
  endfunction

  initial begin
    int k;
    string s;
    bit inval;
    rst_n = 1'b0;
    clear = 1'b0;
    start = 1'b0;
    num_ready = 1'b0;
    buf_invalid = 1'b0;
    load("");
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("post-reset");

    vt[0] = '{"12 -7  0", 1'b0, 0, 3, 12, -7, 0, 0};
    vt[1] = '{"12 -7  0", 1'b0, 1, 3, 12, -7, 0, 0};
    vt[2] = '{"2147483647 -2147483648", 1'b0, 2, 2, 2147483647, int'(32'h8000_0000), 0, 0};
`ifdef ASCII_NUM_PARSER_SAT_EN
    vt[3] = '{"2147483648", 1'b0, 0, 1, 2147483647, 0, 0, 0};
    vt[12] = '{"-2147483649", 1'b0, 0, 1, int'(32'h8000_0000), 0, 0, 0};
`else
    vt[3] = '{"2147483648", 1'b0, 0, 0, 0, 0, 0, 3};
    vt[12] = '{"-2147483649", 1'b0, 0, 0, 0, 0, 0, 3};
`endif
    vt[4] = '{"5-3", 1'b0, 0, 0, 0, 0, 0, 2};
    vt[5] = '{"--1", 1'b0, 0, 0, 0, 0, 0, 2};
    vt[6] = '{"4 -", 1'b0, 0, 1, 4, 0, 0, 2};
    vt[7] = '{"12", 1'b1, 0, 0, 0, 0, 0, 1};
    vt[8] = '{"", 1'b0, 0, 0, 0, 0, 0, 0};
    vt[9] = '{"   ", 1'b0, 0, 0, 0, 0, 0, 0};
    vt[10] = '{" -0  -12 ", 1'b0, 2, 2, 0, -12, 0, 0};
    vt[11] = '{"9x", 1'b0, 0, 0, 0, 0, 0, 2};
    vt[13] = '{"- 4", 1'b0, 0, 0, 0, 0, 0, 2};
    vt[14] = '{"007 3", 1'b0, 1, 2, 7, 3, 0, 0};
    for (int i = 0; i < 15; i++) begin
      exp_q.delete();
      if (vt[i].n > 0) exp_q.push_back(vt[i].v0);
      if (vt[i].n > 1) exp_q.push_back(vt[i].v1);
      if (vt[i].n > 2) exp_q.push_back(vt[i].v2);
      exp_code = vt[i].code;
      run(vt[i].s, vt[i].inval, vt[i].rmode);
      compare($sformatf("vec%0d", i));
    end

    exp_q.delete();
    for (int i = 1; i <= 9; i++) exp_q.push_back(i);
    exp_code = 0;
    run("1 2 3 4 5 6 7 8 9", 1'b0, 2);
    compare("count_sat");

    exp_q = '{3};
    run("3", 1'b0, 0);
    compare("single");
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("restart ignored done", done, 1);
    check("restart ignored count", num_count, 1);
    check("restart ignored valid", num_valid, 0);

    pulse_clear();
    load("111 222 333 444");
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check_zero("clear scan");
    exp_q = '{8, -9};
    run("8 -9", 1'b0, 0);
    compare("after clear scan");

    pulse_clear();
    load("5 6");
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!num_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("emit seen", num_valid, 1);
    repeat (3) @(negedge clk);
    check("stall data", num_data, 5);
    check("stall valid", num_valid, 1);
    check("stall count", num_count, 0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check_zero("clear emit");
    exp_q = '{-31, 4};
    run("-31 4", 1'b0, 1);
    compare("after clear emit");

    pulse_clear();
    load("77 88 99");
    @(negedge clk);
    num_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    num_ready = 1'b0;
    @(negedge clk);
    check_zero("after reset");
    exp_q = '{42};
    run(" 42", 1'b0, 0);
    compare("after reset run");

    for (int r = 0; r < 30; r++) begin
      s = gen();
      inval = $urandom_range(0, 19) == 0;
      model(s, inval);
      run(s, inval, r % 3);
      compare($sformatf("rand%0d '%s'", r, s));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
